// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: signal bundle between the ID/EX pipeline datapath and its hazard unit.
// Suffixes are from the hazard unit's point of view (_i into it, _o out of it).
interface pipe_hazard_if #(parameter int CNT_W = 16);
    logic             id_valid_i;
    logic [1:0]       id_inst_type_i;
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_use_rs_i;
    logic             id_use_rt_i;
    logic             id_reg_write_i;
    logic [4:0]       id_dest_i;
    logic             ex_br_taken_i;
    logic             stall_o;
    logic             flush_id_o;
    logic             flush_ex_o;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    modport master (
        output id_valid_i, id_inst_type_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_reg_write_i, id_dest_i, ex_br_taken_i,
        input  stall_o, flush_id_o, flush_ex_o, fwd_a_o, fwd_b_o, state_o, stall_cnt_o, flush_cnt_o
    );
    modport slave (
        input  id_valid_i, id_inst_type_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_reg_write_i, id_dest_i, ex_br_taken_i,
        output stall_o, flush_id_o, flush_ex_o, fwd_a_o, fwd_b_o, state_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard.sv
// pipe_hazard: load-use stall, jump/branch flush and EX operand forwarding for a 5-stage MIPS pipe.
// Tracks EX/MEM/WB destinations in shadow records; counts stall and flush cycles with saturation.
module pipe_hazard #(parameter int CNT_W = 16) (
    input logic clk,
    input logic rst,
    pipe_hazard_if.slave hz
);
    localparam logic [1:0] T_J  = 2'b01;
    localparam logic [1:0] T_LW = 2'b10;
    typedef enum logic [1:0] {RUN = 2'b00, LD_STALL = 2'b01, BR_FLUSH = 2'b10} state_t;
    typedef struct packed {
        logic       valid;
        logic       rw;
        logic [4:0] dest;
        logic       is_lw;
    } rec_t;
    function automatic logic hit(rec_t r, logic use_src, logic [4:0] src);
        return r.valid && r.dest != 5'd0 && use_src && src == r.dest;
    endfunction
    state_t           state_q, state_d;
    rec_t             sh_q [3];
    rec_t             ex_d;
    logic [1:0]       fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, stall_cnt_d, flush_cnt_d;
    logic             load_use, stall, flush_id, flush_ex, load_ex;
    always_comb begin
        load_use = !hz.ex_br_taken_i && state_q != LD_STALL && hz.id_valid_i && sh_q[0].is_lw
                   && (hit(sh_q[0], hz.id_use_rs_i, hz.id_rs_i) || hit(sh_q[0], hz.id_use_rt_i, hz.id_rt_i));
        stall    = load_use;
        flush_ex = hz.ex_br_taken_i || load_use;
        flush_id = hz.ex_br_taken_i || (!load_use && hz.id_valid_i && hz.id_inst_type_i == T_J);
        state_d  = hz.ex_br_taken_i ? BR_FLUSH : load_use ? LD_STALL : RUN;
        load_ex  = hz.id_valid_i && !flush_ex;
        ex_d     = load_ex ? rec_t'{1'b1, hz.id_reg_write_i, hz.id_dest_i, hz.id_inst_type_i == T_LW} : rec_t'(0);
        // nearest producer wins: EX/MEM result before MEM/WB data
        fwd_a_d  = !load_ex ? 2'b00
                 : (sh_q[0].rw && hit(sh_q[0], hz.id_use_rs_i, hz.id_rs_i)) ? 2'b01
                 : (sh_q[1].rw && hit(sh_q[1], hz.id_use_rs_i, hz.id_rs_i)) ? 2'b10 : 2'b00;
        fwd_b_d  = !load_ex ? 2'b00
                 : (sh_q[0].rw && hit(sh_q[0], hz.id_use_rt_i, hz.id_rt_i)) ? 2'b01
                 : (sh_q[1].rw && hit(sh_q[1], hz.id_use_rt_i, hz.id_rt_i)) ? 2'b10 : 2'b00;
        stall_cnt_d = stall_cnt_q + CNT_W'(stall && ~&stall_cnt_q);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_id && ~&flush_cnt_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            sh_q        <= '{default: '0};
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= '{ex_d, sh_q[0], sh_q[1]};
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign hz.stall_o     = stall;
    assign hz.flush_id_o  = flush_id;
    assign hz.flush_ex_o  = flush_ex;
    assign hz.fwd_a_o     = fwd_a_q;
    assign hz.fwd_b_o     = fwd_b_q;
    assign hz.state_o     = state_q;
    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard.sv
// tb_pipe_hazard: directed instruction sequences with a scoreboard of post-edge expectations.
module tb_pipe_hazard;
    localparam logic [1:0] N = 2'b00, J = 2'b01, L = 2'b10;
    typedef struct packed {
        logic [1:0] st;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   sc;
    exp_t q[$];
    pipe_hazard_if #(.CNT_W(4)) hz();
    pipe_hazard #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .hz(hz));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input string tag, input logic v, input logic [1:0] ty, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt, input logic rw,
                        input logic [4:0] dst, input logic br, input logic es, input logic efi,
                        input logic efe, input logic [1:0] est, input logic [1:0] efa,
                        input logic [1:0] efb, input int esc, input int efc);
        exp_t e;
        @(negedge clk);
        hz.id_valid_i = v; hz.id_inst_type_i = ty; hz.id_rs_i = rs; hz.id_rt_i = rt;
        hz.id_use_rs_i = urs; hz.id_use_rt_i = urt; hz.id_reg_write_i = rw; hz.id_dest_i = dst;
        hz.ex_br_taken_i = br;
        #1;
        chk({tag, ".stall"}, hz.stall_o, es);
        chk({tag, ".flush_id"}, hz.flush_id_o, efi);
        chk({tag, ".flush_ex"}, hz.flush_ex_o, efe);
        q.push_back('{est, efa, efb, 4'(esc), 4'(efc)});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".state"}, hz.state_o, e.st);
        chk({tag, ".fwd_a"}, hz.fwd_a_o, e.fa);
        chk({tag, ".fwd_b"}, hz.fwd_b_o, e.fb);
        chk({tag, ".stall_cnt"}, hz.stall_cnt_o, e.sc);
        chk({tag, ".flush_cnt"}, hz.flush_cnt_o, e.fc);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        hz.id_valid_i = 0; hz.id_inst_type_i = N; hz.id_rs_i = 0; hz.id_rt_i = 0;
        hz.id_use_rs_i = 0; hz.id_use_rt_i = 0; hz.id_reg_write_i = 0; hz.id_dest_i = 0;
        hz.ex_br_taken_i = 0;
        #2;
        chk("rst.state", hz.state_o, 0);
        chk("rst.fwd_a", hz.fwd_a_o, 0);
        chk("rst.fwd_b", hz.fwd_b_o, 0);
        chk("rst.stall_cnt", hz.stall_cnt_o, 0);
        chk("rst.flush_cnt", hz.flush_cnt_o, 0);
        chk("rst.stall", hz.stall_o, 0);
        chk("rst.flush_id", hz.flush_id_o, 0);
        chk("rst.flush_ex", hz.flush_ex_o, 0);
        @(negedge clk) rst = 0;
        // load-use: lw $8 ; add $9,$8,$8
        step("lw8",      1, L, 1, 8, 1, 0, 1, 8, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        step("lu_stall", 1, N, 8, 8, 1, 1, 1, 9, 0,  1, 0, 1,  1, 0, 0, 1, 0);
        step("lu_fwd",   1, N, 8, 8, 1, 1, 1, 9, 0,  0, 0, 0,  0, 2, 2, 1, 0);
        step("nop1",     0, N, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);
        step("nop2",     0, N, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);
        // ALU chain
        step("addu3",    1, N, 1, 2, 1, 1, 1, 3, 0,  0, 0, 0,  0, 0, 0, 1, 0);
        step("addu4",    1, N, 3, 3, 1, 1, 1, 4, 0,  0, 0, 0,  0, 1, 1, 1, 0);
        step("or5",      1, N, 3, 4, 1, 1, 1, 5, 0,  0, 0, 0,  0, 2, 1, 1, 0);
        // register 0 never stalls or forwards
        step("lw0",      1, L, 1, 0, 1, 0, 1, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0);
        step("rd0",      1, N, 0, 0, 1, 1, 1, 6, 0,  0, 0, 0,  0, 0, 0, 1, 0);
        // jumps
        step("j",        1, J, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,  0, 0, 0, 1, 1);
        step("jal",      1, J, 0, 0, 0, 0, 1, 31, 0, 0, 1, 0,  0, 0, 0, 1, 2);
        step("rd31",     1, N, 31, 0, 1, 0, 1, 10, 0, 0, 0, 0, 0, 1, 0, 1, 2);
        // branch beats load-use
        step("lw7",      1, L, 1, 7, 1, 0, 1, 7, 0,  0, 0, 0,  0, 0, 0, 1, 2);
        step("br_lu",    1, N, 7, 7, 1, 1, 1, 11, 1, 0, 1, 1,  2, 0, 0, 1, 3);
        step("br_run",   1, N, 7, 7, 1, 1, 1, 11, 0, 0, 0, 0,  0, 2, 2, 1, 3);
        // saturation: 20 separate load-use stalls on a 4-bit counter
        sc = 1;
        for (int i = 0; i < 20; i++) begin
            step("sat_lw",   1, L, 1, 8, 1, 0, 1, 8, 0,  0, 0, 0,  0, 0, 0, sc, 3);
            sc = (sc < 15) ? sc + 1 : 15;
            step("sat_stl",  1, N, 8, 8, 1, 1, 1, 9, 0,  1, 0, 1,  1, 0, 0, sc, 3);
            step("sat_fwd",  1, N, 8, 8, 1, 1, 1, 9, 0,  0, 0, 0,  0, 2, 2, sc, 3);
        end
        // reset in the middle of a load-use stall
        step("pre_lw",   1, L, 1, 8, 1, 0, 1, 8, 0,  0, 0, 0,  0, 0, 0, 15, 3);
        step("pre_stl",  1, N, 8, 8, 1, 1, 1, 9, 0,  1, 0, 1,  1, 0, 0, 15, 3);
        rst = 1;
        #1;
        chk("mid_rst.state", hz.state_o, 0);
        chk("mid_rst.fwd_a", hz.fwd_a_o, 0);
        chk("mid_rst.fwd_b", hz.fwd_b_o, 0);
        chk("mid_rst.stall_cnt", hz.stall_cnt_o, 0);
        chk("mid_rst.flush_cnt", hz.flush_cnt_o, 0);
        chk("mid_rst.stall", hz.stall_o, 0);
        @(negedge clk) rst = 0;
        step("post_rst", 1, N, 8, 8, 1, 1, 1, 9, 0,  0, 0, 0,  0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
